nes_pad_responder: RTL and testbench

NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

---
 rtl/nes_pad_responder_if.sv | 20 ++
 rtl/nes_pad_responder.sv | 113 +++++++++++
 tb/tb_nes_pad_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/nes_pad_responder_if.sv
// Pad-side bundle between the console connector and the responder.
// The console drives latch/pulse/buttons; the responder drives the serial line and status.
interface nes_pad_responder_if;
  logic       latch;
  logic       pulse;
  logic [7:0] buttons;
  logic       data_out;
  logic       frame_done;
  logic [1:0] state_dbg;

  modport master (
    output latch, pulse, buttons,
    input  data_out, frame_done, state_dbg
  );

  modport slave (
    input  latch, pulse, buttons,
    output data_out, frame_done, state_dbg
  );
endinterface

// File: rtl/nes_pad_responder.sv
// NES controller emulation: captures the pad on the console latch strobe and shifts it
// out one bit per console pulse, active-low, after synchronizing both strobes into clk.
module nes_pad_responder (
  input  logic                 clk,
  input  logic                 rst,
  nes_pad_responder_if.slave   pad
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t     state, state_next;
  logic [7:0] sr, sr_next;
  logic [3:0] cnt, cnt_next;
  logic       data_out_q, data_out_next;
  logic       frame_done_q, frame_done_next;

  logic latch_s1, latch_s2, latch_h;
  logic pulse_s1, pulse_s2, pulse_h;
  logic latch_rise, latch_fall, pulse_rise;

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the chain.
    if (!rst) begin
      latch_s1 <= 1'b0;
      latch_s2 <= 1'b0;
      latch_h  <= 1'b0;
      pulse_s1 <= 1'b0;
      pulse_s2 <= 1'b0;
      pulse_h  <= 1'b0;
    end else begin
      latch_s1 <= pad.latch;
      latch_s2 <= latch_s1;
      latch_h  <= latch_s2;
      pulse_s1 <= pad.pulse;
      pulse_s2 <= pulse_s1;
      pulse_h  <= pulse_s2;
    end
  end

  assign latch_rise = latch_s2 & ~latch_h;
  assign latch_fall = ~latch_s2 & latch_h;
  assign pulse_rise = pulse_s2 & ~pulse_h;

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      sr           <= 8'h00;
      cnt          <= 4'd0;
      data_out_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_next;
      sr           <= sr_next;
      cnt          <= cnt_next;
      data_out_q   <= data_out_next;
      frame_done_q <= frame_done_next;
    end
  end

  // Next-state logic. Outside LOAD a high synchronized latch can only appear as its
  // rising edge (LOAD is held while latch stays high), so the edge covers "latch=1".
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    if (latch_rise) begin
      state_next = LOAD;
      sr_next    = pad.buttons;
      cnt_next   = 4'd0;
    end else begin
      unique case (state)
        LOAD: begin
          if (latch_fall) state_next = SHIFT;
          else            sr_next    = pad.buttons;
        end
        SHIFT: begin
          if (pulse_rise) begin
            sr_next  = {1'b0, sr[7:1]};
            cnt_next = (cnt == 4'd8) ? cnt : cnt + 4'd1;
            if (cnt == 4'd7) state_next = DONE;
          end
        end
        IDLE, DONE: ;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic: values registered alongside the state they belong to.
  always_comb begin
    frame_done_next = (state == SHIFT) && (state_next == DONE);
    unique case (state_next)
      IDLE:        data_out_next = 1'b1;
      DONE:        data_out_next = 1'b0;
      LOAD, SHIFT: data_out_next = ~sr_next[0];
      default:     data_out_next = 1'b1;
    endcase
  end

  assign pad.data_out   = data_out_q;
  assign pad.frame_done = frame_done_q;
  assign pad.state_dbg  = state;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: a frame-level reference model checked every
// cycle, plus literal expectations for the key console scenarios.
module tb_nes_pad_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nes_pad_responder_if pad ();

  nes_pad_responder dut (
    .clk (clk),
    .rst (rst),
    .pad (pad)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int fd_count  = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: the console view of the pad. Strobes reach the logic two clocks
  // late; a frame is a captured word read out one bit index per pulse edge.
  typedef enum {M_IDLE, M_LOAD, M_SHIFT, M_DONE} mode_t;
  mode_t      m_mode = M_IDLE;
  logic [7:0] m_word = 8'h00;
  int         m_nbits = 0;
  bit         m_l1, m_l2, m_l3, m_p1, m_p2, m_p3;
  bit         exp_out = 1'b1;
  bit         exp_fd  = 1'b0;
  int         exp_state = 0;
  bit         model_valid = 1'b0;

  always @(posedge clk) begin
    exp_fd = 1'b0;
    if (!rst) begin
      m_mode = M_IDLE; m_word = 8'h00; m_nbits = 0;
      {m_l1, m_l2, m_l3, m_p1, m_p2, m_p3} = '0;
      model_valid = 1'b1;
    end else begin
      if (m_l2) begin
        m_mode  = M_LOAD;
        m_word  = pad.buttons;
        m_nbits = 0;
      end else begin
        case (m_mode)
          M_LOAD:  m_mode = M_SHIFT;
          M_SHIFT: if (m_p2 && !m_p3) begin
                     m_nbits++;
                     if (m_nbits == 8) begin
                       m_mode = M_DONE;
                       exp_fd = 1'b1;
                     end
                   end
          default: ;
        endcase
      end
      m_l3 = m_l2; m_l2 = m_l1; m_l1 = pad.latch;
      m_p3 = m_p2; m_p2 = m_p1; m_p1 = pad.pulse;
    end
    case (m_mode)
      M_IDLE:  begin exp_out = 1'b1; exp_state = 0; end
      M_LOAD:  begin exp_out = ~m_word[m_nbits]; exp_state = 1; end
      M_SHIFT: begin exp_out = (m_nbits < 8) ? ~m_word[m_nbits] : 1'b1; exp_state = 2; end
      default: begin exp_out = 1'b0; exp_state = 3; end
    endcase
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_data_out",   int'(pad.data_out),   int'(exp_out));
      check("model_frame_done", int'(pad.frame_done), int'(exp_fd));
      check("model_state_dbg",  int'(pad.state_dbg),  exp_state);
      if (pad.frame_done) fd_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_latch();
    pad.latch = 1'b1;
    tick(3);
    pad.latch = 1'b0;
    tick(4);
  endtask

  task automatic do_pulse();
    pad.pulse = 1'b1;
    tick(3);
    pad.pulse = 1'b0;
    tick(3);
  endtask

  // Reads a whole frame: the bit seen before each pulse must be the inverted capture.
  task automatic frame_expect(input logic [7:0] word);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b = ~word[i];
      check("frame_bit", int'(pad.data_out), int'(b));
      do_pulse();
    end
    check("frame_end_state", int'(pad.state_dbg), 3);
    check("frame_end_data",  int'(pad.data_out),  0);
  endtask

  initial begin
    logic [7:0] seq;
    pad.latch   = 1'b0;
    pad.pulse   = 1'b0;
    pad.buttons = 8'h00;

    tick(3);
    check("reset_data_out",   int'(pad.data_out),   1);
    check("reset_frame_done", int'(pad.frame_done), 0);
    check("reset_state",      int'(pad.state_dbg),  0);
    rst = 1'b1;
    tick(5);
    check("idle_hold_state", int'(pad.state_dbg), 0);
    do_pulse();
    check("idle_pulse_data", int'(pad.data_out),  1);
    check("idle_pulse_state", int'(pad.state_dbg), 0);

    // Normal frame with A and Start pressed.
    pad.buttons = 8'b0000_1001;
    do_latch();
    check("frame1_state", int'(pad.state_dbg), 2);
    seq = 8'b1111_0110;
    for (int i = 0; i < 8; i++) begin
      check("frame1_bit", int'(pad.data_out), int'(seq[i]));
      if (i == 0) begin
        pad.pulse = 1'b1;
        tick(2);
        check("latency_2clk", int'(pad.data_out), 0);
        tick(1);
        check("latency_3clk", int'(pad.data_out), 1);
        pad.pulse = 1'b0;
        tick(3);
      end else begin
        do_pulse();
      end
    end
    check("frame1_done_data",  int'(pad.data_out),  0);
    check("frame1_done_state", int'(pad.state_dbg), 3);
    check("frame1_fd_count",   fd_count, 1);

    // Overread past the end of the frame.
    repeat (3) do_pulse();
    check("overread_data",  int'(pad.data_out),  0);
    check("overread_state", int'(pad.state_dbg), 3);
    check("overread_fd",    fd_count, 1);

    // Buttons change just after the capture window closes.
    pad.buttons = 8'h00;
    pad.latch = 1'b1;
    tick(3);
    pad.latch = 1'b0;
    tick(2);
    pad.buttons = 8'hFF;
    tick(2);
    check("capture_state", int'(pad.state_dbg), 2);
    frame_expect(8'h00);
    check("capture_fd", fd_count, 2);

    // Latch and pulse rising together mid-frame: latch wins, nothing shifts.
    pad.buttons = 8'b0000_0010;
    do_latch();
    do_pulse();
    do_pulse();
    pad.latch = 1'b1;
    pad.pulse = 1'b1;
    tick(3);
    check("simul_state", int'(pad.state_dbg), 1);
    check("simul_data",  int'(pad.data_out),  1);
    pad.latch = 1'b0;
    pad.pulse = 1'b0;
    tick(4);
    check("simul_no_fd", fd_count, 2);
    frame_expect(8'b0000_0010);
    check("simul_fd", fd_count, 3);

    // Re-latch after four pulses aborts the frame.
    pad.buttons = 8'hA5;
    do_latch();
    repeat (4) do_pulse();
    pad.buttons = 8'h3C;
    do_latch();
    check("relatch_no_fd", fd_count, 3);
    frame_expect(8'h3C);
    check("relatch_fd", fd_count, 4);

    // Reset for one clock after five pulses.
    pad.buttons = 8'h5A;
    do_latch();
    repeat (5) do_pulse();
    rst = 1'b0;
    tick(1);
    check("midrst_data",  int'(pad.data_out),  1);
    check("midrst_state", int'(pad.state_dbg), 0);
    rst = 1'b1;
    repeat (3) do_pulse();
    check("postrst_data",  int'(pad.data_out),  1);
    check("postrst_state", int'(pad.state_dbg), 0);
    check("postrst_no_fd", fd_count, 4);
    do_latch();
    check("postrst_latch_state", int'(pad.state_dbg), 2);
    frame_expect(8'h5A);
    check("postrst_fd", fd_count, 5);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
